// File: rtl/neuron_host_sequencer.sv
// Host-side sequencer: buffers N_WORDS data words plus a threshold from a valid/ready
// stream, then replays them to the neuron engine. Optional build macro: HOST_TIMEOUT_EN.
module neuron_host_sequencer #(
  parameter int DATA_W        = 8,
  parameter int RES_W         = 8,
  parameter int N_WORDS       = 64,
  parameter int CS_SETUP      = 2,
  parameter int THRESH_CYCLES = 3,
  parameter int TIMEOUT       = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              eng_chip_sel,
  output logic              eng_wr_en,
  output logic [DATA_W-1:0] eng_data,
  input  logic              eng_output_ready,
  input  logic [RES_W-1:0]  eng_result,
  output logic [RES_W-1:0]  result,
  output logic              done,
  output logic              busy,
  output logic              timeout_err
);

  localparam int IDX_W = $clog2(N_WORDS + 1);
  localparam int AW    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_CS_WAIT  = 3'd2,
    S_BURST    = 3'd3,
    S_THRESH   = 3'd4,
    S_WAIT_RES = 3'd5,
    S_RELEASE  = 3'd6
  } state_t;

  state_t              state_r, state_nx;
  logic [IDX_W-1:0]    idx_r, idx_nx;
  logic [TW-1:0]       cnt_r, cnt_nx;
  logic [1:0]          rst_pipe_r;
  logic                arst_s;
  logic                hs_s;
  logic                cap_s;
  logic [DATA_W-1:0]   data_nx;
  logic [DATA_W-1:0]   thresh_r;
  logic [DATA_W-1:0]   buf_r [0:N_WORDS-1];
  logic                in_ready_r, chip_sel_r, wr_en_r, done_r, busy_r;
  logic [DATA_W-1:0]   eng_data_r;
  logic [RES_W-1:0]    result_r;
`ifdef HOST_TIMEOUT_EN
  logic                tmo_s;
  logic                timeout_err_r;
`endif

  // Reset synchroniser: assertion is immediate, release follows two clock edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_pipe_r <= 2'b11;
    else     rst_pipe_r <= {rst_pipe_r[0], 1'b0};
  end

  assign arst_s = rst_pipe_r[1];

  // State and counter registers.
  always_ff @(posedge clk or posedge arst_s) begin
    if (arst_s) begin
      state_r <= S_IDLE;
      idx_r   <= {IDX_W{1'b0}};
      cnt_r   <= {TW{1'b0}};
    end else begin
      state_r <= state_nx;
      idx_r   <= idx_nx;
      cnt_r   <= cnt_nx;
    end
  end

  // Next-state, counter and engine data decode.
  always_comb begin
    state_nx = state_r;
    idx_nx   = idx_r;
    cnt_nx   = cnt_r;
    cap_s    = 1'b0;
    hs_s     = in_ready_r & in_valid;
`ifdef HOST_TIMEOUT_EN
    tmo_s    = 1'b0;
`endif
    case (state_r)
      S_IDLE: begin
        idx_nx = {IDX_W{1'b0}};
        cnt_nx = {TW{1'b0}};
        if (start) state_nx = S_LOAD;
        else       state_nx = S_IDLE;
      end
      S_LOAD: begin
        if (hs_s && (idx_r == IDX_W'(N_WORDS))) begin
          state_nx = S_CS_WAIT;
          idx_nx   = {IDX_W{1'b0}};
          cnt_nx   = {TW{1'b0}};
        end else if (hs_s) begin
          idx_nx = idx_r + IDX_W'(1);
        end else begin
          idx_nx = idx_r;
        end
      end
      S_CS_WAIT: begin
        if (cnt_r == TW'(CS_SETUP - 1)) begin
          state_nx = S_BURST;
          idx_nx   = {IDX_W{1'b0}};
          cnt_nx   = {TW{1'b0}};
        end else begin
          cnt_nx = cnt_r + TW'(1);
        end
      end
      S_BURST: begin
        if (idx_r == IDX_W'(N_WORDS - 1)) begin
          state_nx = S_THRESH;
          idx_nx   = {IDX_W{1'b0}};
          cnt_nx   = {TW{1'b0}};
        end else begin
          idx_nx = idx_r + IDX_W'(1);
        end
      end
      S_THRESH: begin
        if (cnt_r == TW'(THRESH_CYCLES - 1)) begin
          state_nx = S_WAIT_RES;
          cnt_nx   = {TW{1'b0}};
        end else begin
          cnt_nx = cnt_r + TW'(1);
        end
      end
      S_WAIT_RES: begin
        if (eng_output_ready) begin
          state_nx = S_RELEASE;
          cap_s    = 1'b1;
        end
`ifdef HOST_TIMEOUT_EN
        else if (cnt_r == TW'(TIMEOUT - 1)) begin
          state_nx = S_RELEASE;
          tmo_s    = 1'b1;
        end else begin
          cnt_nx = cnt_r + TW'(1);
        end
`else
        else begin
          state_nx = S_WAIT_RES;
        end
`endif
      end
      S_RELEASE: state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copy lines up with state_r.
    case (state_nx)
      S_BURST:  data_nx = buf_r[idx_nx[AW-1:0]];
      S_THRESH: data_nx = thresh_r;
      default:  data_nx = {DATA_W{1'b0}};
    endcase
  end

  // Registered host and engine outputs.
  always_ff @(posedge clk or posedge arst_s) begin
    if (arst_s) begin
      in_ready_r <= 1'b0;
      chip_sel_r <= 1'b0;
      wr_en_r    <= 1'b0;
      eng_data_r <= {DATA_W{1'b0}};
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      result_r   <= {RES_W{1'b0}};
    end else begin
      in_ready_r <= (state_nx == S_LOAD);
      chip_sel_r <= (state_nx == S_CS_WAIT) || (state_nx == S_BURST) ||
                    (state_nx == S_THRESH)  || (state_nx == S_WAIT_RES);
      wr_en_r    <= (state_nx == S_BURST) || (state_nx == S_THRESH);
      eng_data_r <= data_nx;
      done_r     <= cap_s;
      busy_r     <= (state_nx != S_IDLE);
      if (cap_s) result_r <= eng_result;
      else       result_r <= result_r;
    end
  end

  // Threshold register, loaded by the final handshake of LOAD.
  always_ff @(posedge clk or posedge arst_s) begin
    if (arst_s)                                    thresh_r <= {DATA_W{1'b0}};
    else if (hs_s && (idx_r == IDX_W'(N_WORDS)))  thresh_r <= in_data;
    else                                           thresh_r <= thresh_r;
  end

  // Word buffer; contents are always rewritten before they are replayed.
  always_ff @(posedge clk) begin
    if (hs_s && (idx_r != IDX_W'(N_WORDS))) buf_r[idx_r[AW-1:0]] <= in_data;
  end

`ifdef HOST_TIMEOUT_EN
  // Sticky timeout flag, cleared when a new inference is accepted.
  always_ff @(posedge clk or posedge arst_s) begin
    if (arst_s)                           timeout_err_r <= 1'b0;
    else if (state_r == S_IDLE && start)  timeout_err_r <= 1'b0;
    else if (tmo_s)                       timeout_err_r <= 1'b1;
    else                                  timeout_err_r <= timeout_err_r;
  end
  assign timeout_err = timeout_err_r;
`else
  assign timeout_err = 1'b0;
`endif

  assign in_ready     = in_ready_r;
  assign eng_chip_sel = chip_sel_r;
  assign eng_wr_en    = wr_en_r;
  assign eng_data     = eng_data_r;
  assign done         = done_r;
  assign busy         = busy_r;
  assign result       = result_r;

endmodule

// File: tb/tb_neuron_host_sequencer.sv
// Directed bench for neuron_host_sequencer: table of inference vectors plus
// hand-written reset-mid-burst and (with HOST_TIMEOUT_EN) timeout sequences.
module tb_neuron_host_sequencer;

  localparam int NW = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       eng_chip_sel;
  logic       eng_wr_en;
  logic [7:0] eng_data;
  logic       eng_output_ready;
  logic [7:0] eng_result;
  logic [7:0] result;
  logic       done;
  logic       busy;
  logic       timeout_err;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [7:0] base;
    logic [7:0] thr;
    logic [7:0] res;
    bit         stall;
    bit         poke;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  neuron_host_sequencer #(
    .DATA_W(8), .RES_W(8), .N_WORDS(NW), .CS_SETUP(2), .THRESH_CYCLES(3), .TIMEOUT(10)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .eng_chip_sel(eng_chip_sel), .eng_wr_en(eng_wr_en),
    .eng_data(eng_data), .eng_output_ready(eng_output_ready), .eng_result(eng_result),
    .result(result), .done(done), .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
    end
  endtask

  task automatic stream(input logic [7:0] base, input logic [7:0] thr, input bit stall);
    int n   = 0;
    int cyc = 0;
    bit tog = 1'b1;
    bit hs;
    while (n < NW + 1 && cyc < 1000) begin
      in_valid = stall ? tog : 1'b1;
      tog      = ~tog;
      in_data  = (n < NW) ? 8'(base + n) : thr;
      hs       = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (hs) n++;
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    chk("load_handshakes", n, NW + 1);
  endtask

  task automatic monitor(input vec_t v);
    int k = 0, setup = 0, nwr = 0, bad = 0, wbad = 0;
    logic [7:0] expd;
    while (!eng_chip_sel && k < 2000) begin @(negedge clk); k++; end
    chk("cs_rise", eng_chip_sel, 1);
    while (eng_chip_sel && !eng_wr_en && setup < 100) begin setup++; @(negedge clk); end
    chk("cs_setup_cycles", setup, 2);
    while (eng_wr_en && nwr < 200) begin
      expd = (nwr < NW) ? 8'(v.base + nwr) : v.thr;
      if (eng_data !== expd || eng_chip_sel !== 1'b1) bad++;
      if (v.poke && nwr == 30) start = 1'b1;
      else start = 1'b0;
      nwr++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("wr_en_run_len", nwr, NW + 3);
    chk("burst_data_errs", bad, 0);
    for (int i = 0; i < 5; i++) begin
      if (eng_chip_sel !== 1'b1 || eng_wr_en !== 1'b0 || eng_data !== 8'h00 || done !== 1'b0) wbad++;
      if (i < 4) @(negedge clk);
    end
    chk("wait_res_bus", wbad, 0);
    eng_output_ready = 1'b1;
    eng_result       = v.res;
    @(negedge clk);
    eng_output_ready = 1'b0;
    eng_result       = ~v.res;
    chk("done_pulse", done, 1);
    chk("result_capture", result, v.res);
    chk("release_cs_low", {eng_chip_sel, eng_wr_en, busy}, 3'b001);
    @(negedge clk);
    chk("after_done", {done, busy, eng_chip_sel}, 3'b000);
    chk("result_held", result, v.res);
    repeat (3) @(negedge clk);
    chk("no_queued_start", busy, 0);
  endtask

  task automatic run_vector(input vec_t v);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_accept", {busy, in_ready, timeout_err}, 3'b110);
    fork
      stream(v.base, v.thr, v.stall);
      monitor(v);
    join
  endtask

  initial begin
    int k;
    int c;
    int sawdone;
    vecs[0] = '{base: 8'h00, thr: 8'h20, res: 8'hA5, stall: 1'b0, poke: 1'b0};
    vecs[1] = '{base: 8'h00, thr: 8'h20, res: 8'hA5, stall: 1'b1, poke: 1'b0};
    vecs[2] = '{base: 8'hD0, thr: 8'h7F, res: 8'h3C, stall: 1'b0, poke: 1'b1};
    vecs[3] = '{base: 8'hFF, thr: 8'h00, res: 8'h5B, stall: 1'b1, poke: 1'b1};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    eng_output_ready = 1'b0; eng_result = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_state", {eng_chip_sel, eng_wr_en, eng_data, in_ready, busy, done, result, timeout_err}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_after_reset", {busy, in_ready, eng_chip_sel}, 0);

    for (int i = 0; i < 4; i++) run_vector(vecs[i]);

    // Reset asserted while burst word 30 is on the bus.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    fork
      stream(8'h00, 8'h20, 1'b0);
      begin
        k = 0;
        while (!(eng_wr_en && eng_data == 8'd30) && k < 2000) begin @(negedge clk); k++; end
        chk("reached_word30", (k < 2000), 1);
        rst = 1'b1;
        #1;
        chk("mid_reset_outputs",
            {eng_chip_sel, eng_wr_en, eng_data, in_ready, busy, done, result, timeout_err}, 0);
      end
    join
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    run_vector(vecs[0]);

`ifdef HOST_TIMEOUT_EN
    // Engine never answers: expect a 10-cycle wait, then release with the error flag.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    fork
      stream(8'h11, 8'h22, 1'b0);
      begin
        k = 0;
        while (!eng_wr_en && k < 2000) begin @(negedge clk); k++; end
        while (eng_wr_en && k < 2000) begin @(negedge clk); k++; end
        c = 0; sawdone = 0;
        while (eng_chip_sel && !eng_wr_en && c < 100) begin
          if (done) sawdone++;
          c++;
          @(negedge clk);
        end
        chk("timeout_wait_cycles", c, 10);
        chk("timeout_flag", timeout_err, 1);
        chk("timeout_no_done", {sawdone[0], done}, 2'b00);
        chk("timeout_cs_released", eng_chip_sel, 0);
        chk("timeout_result_kept", result, 8'hA5);
        @(negedge clk);
        chk("timeout_sticky", {timeout_err, busy}, 2'b10);
      end
    join
    run_vector(vecs[1]);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/neuron_host_sequencer.md
Name: neuron_host_sequencer

Overview:
- Host-side initiator that drives the neuron engine's chip-select / write-enable load protocol.
- Collects N_WORDS input words plus one threshold from an upstream valid/ready stream into a local buffer.
- Replays them to the engine as one unbroken write burst followed by the threshold phase.
- Waits for the engine's output_ready, captures the result, then releases chip_sel and reports done.

Parameters:
- DATA_W, 8: engine data bus width.
- RES_W, 8: engine result width.
- N_WORDS, 64: data words per inference; burst length.
- CS_SETUP, 2: cycles chip_sel is held high before wr_en rises (covers the engine's rst_mem pulse).
- THRESH_CYCLES, 3: cycles the threshold is driven with wr_en high.
- TIMEOUT, 255: max wait cycles for output_ready (only with HOST_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin an inference; ignored unless busy=0.
- in_valid  in  1  upstream word valid.
- in_data  in  DATA_W  upstream word; words 0..N_WORDS-1 are data, word N_WORDS is the threshold.
- in_ready  out  1  high only in LOAD.
- eng_chip_sel  out  1  engine chip select.
- eng_wr_en  out  1  engine write enable.
- eng_data  out  DATA_W  engine write data.
- eng_output_ready  in  1  engine result valid.
- eng_result  in  RES_W  engine result.
- result  out  RES_W  captured result; held until next capture.
- done  out  1  one-cycle pulse when result is valid.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky error flag; cleared by next accepted start (only with HOST_TIMEOUT_EN, else tied 0).

Behaviour:
- Reset (async assert; release synchronised to clk):
  - State IDLE.
  - All outputs 0: eng_chip_sel, eng_wr_en, eng_data, in_ready, result, done, busy, timeout_err.
  - Counters 0.
  - Reset mid-burst drops chip_sel immediately; the engine returns to IDLE on its own.
- IDLE:
  - start=1 → LOAD.
  - idx=0; clear timeout_err.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready handshake writes buf[idx], idx++.
  - Handshake with idx==N_WORDS stores the threshold register → CS_WAIT.
  - Upstream stalls are allowed; nothing is sent to the engine during LOAD.
- CS_WAIT:
  - eng_chip_sel=1, eng_wr_en=0.
  - Hold CS_SETUP cycles → BURST, idx=0.
- BURST:
  - eng_chip_sel=1, eng_wr_en=1, eng_data=buf[idx].
  - Exactly N_WORDS consecutive cycles; wr_en never drops.
  - idx wraps to 0 after N_WORDS-1 → THRESH.
- THRESH:
  - eng_wr_en=1, eng_data=threshold.
  - THRESH_CYCLES cycles → WAIT_RES.
- WAIT_RES:
  - eng_wr_en=0, eng_data=0, chip_sel held.
  - First cycle with eng_output_ready=1 → result<=eng_result, done=1 next cycle → RELEASE.
- RELEASE:
  - eng_chip_sel=0 for one cycle → IDLE.
- start while busy=1: ignored, no queuing.
- Latency start→first eng_wr_en = 1 + (N_WORDS+1 handshakes) + CS_SETUP cycles (full-rate upstream).
- All engine-facing outputs are registered; no combinational path from in_* to eng_*.
- Counters are sized $clog2(N_WORDS+1) and $clog2(TIMEOUT+1).

Optional Feature:
- HOST_TIMEOUT_EN defined:
  - WAIT_RES counts cycles.
  - If the count reaches TIMEOUT without eng_output_ready: timeout_err<=1, no done pulse, result unchanged → RELEASE.
- Not defined:
  - WAIT_RES waits indefinitely.
  - timeout_err is constant 0.

Test Plan:
- Basic: reset, start, stream 0..63 then threshold 0x20 at full rate → chip_sel high 2 cycles before wr_en; eng_data 0..63 then 0x20 ×3 with wr_en continuously high for 67 cycles.
- Result: model engine raises eng_output_ready with eng_result=0xA5 5 cycles after the burst → result=0xA5, done 1 cycle, chip_sel low 1 cycle, busy falls.
- Upstream stall: in_valid toggled 50% during LOAD → engine burst identical to the basic case, with no wr_en gaps.
- Busy start: start pulsed during BURST → ignored; sequence and word count unchanged.
- Reset mid-op: rst asserted at burst word 30 → all outputs 0 immediately; next start runs a clean full sequence.
- Timeout (HOST_TIMEOUT_EN, TIMEOUT=10): never raise eng_output_ready → timeout_err=1 after 10 cycles, no done, chip_sel released; next start clears timeout_err.
